// File: rtl/pwm_fade_sequencer.sv
// Duty-cycle sequencer between the SPI duty register and the PWM peripheral.
// It either passes the duty value through or runs a triangle fade. Define FADE_GAMMA_EN to square-law map the fade output.
module pwm_fade_sequencer #(
  parameter int         PRESCALE_W   = 16,
  parameter logic [7:0] DEFAULT_DUTY = 8'h00
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fade_en,
  input  logic [7:0]            spi_duty,
  input  logic                  spi_duty_wr,
  input  logic [7:0]            step,
  input  logic [PRESCALE_W-1:0] tick_div,
  input  logic [7:0]            hold_ticks,
  output logic [7:0]            duty_out,
  output logic [1:0]            phase,
  output logic                  ramp_done
);

  typedef enum logic [1:0] {
    PASS = 2'b00,
    UP   = 2'b01,
    HOLD = 2'b10,
    DOWN = 2'b11
  } state_t;

  localparam logic [PRESCALE_W-1:0] PRESC_ONE = {{(PRESCALE_W-1){1'b0}}, 1'b1};

  state_t                state_reg, state_next;
  logic [7:0]            ceil_reg, ceil_next;
  logic [7:0]            duty_reg, duty_next;
  logic [PRESCALE_W-1:0] presc_reg, presc_next;
  logic [7:0]            hold_cnt_reg, hold_cnt_next;
  logic                  dir_down_reg, dir_down_next;
  logic                  ramp_done_reg, ramp_done_next;

  logic [7:0] ceil_eff;
  logic [7:0] step_eff;
  logic       tick;
  logic [8:0] up_sum;
  logic [7:0] up_duty;
  logic [7:0] down_duty;

  // A same-cycle SPI write is seen by every decision made in that cycle.
  always_comb begin
    ceil_eff  = spi_duty_wr ? spi_duty : ceil_reg;
    step_eff  = (step == 8'd0) ? 8'd1 : step;
    tick      = (presc_reg >= tick_div);
    up_sum    = {1'b0, duty_reg} + {1'b0, step_eff};
    up_duty   = (up_sum >= {1'b0, ceil_eff}) ? ceil_eff : up_sum[7:0];
    down_duty = (duty_reg <= step_eff) ? 8'd0 : (duty_reg - step_eff);
  end

  always_comb begin
    state_next     = state_reg;
    ceil_next      = ceil_eff;
    duty_next      = duty_reg;
    presc_next     = tick ? '0 : (presc_reg + PRESC_ONE);
    hold_cnt_next  = hold_cnt_reg;
    dir_down_next  = dir_down_reg;
    ramp_done_next = 1'b0;

    if (state_reg == PASS) begin
      duty_next  = ceil_eff;
      presc_next = '0;
      if (fade_en) begin
        state_next = UP;
        duty_next  = 8'd0;
      end
    end else if (!fade_en) begin
      state_next = PASS;
      duty_next  = ceil_eff;
      presc_next = '0;
    end else if (tick) begin
      case (state_reg)
        UP: begin
          duty_next = up_duty;
          if (up_duty == ceil_eff) begin
            state_next    = HOLD;
            dir_down_next = 1'b1;
            hold_cnt_next = 8'd0;
          end
        end
        HOLD: begin
          if (hold_cnt_reg == hold_ticks) begin
            state_next = dir_down_reg ? DOWN : UP;
          end else begin
            hold_cnt_next = hold_cnt_reg + 8'd1;
          end
        end
        DOWN: begin
          duty_next = down_duty;
          if (down_duty == 8'd0) begin
            state_next     = HOLD;
            dir_down_next  = 1'b0;
            hold_cnt_next  = 8'd0;
            ramp_done_next = 1'b1;
          end
        end
        default: state_next = PASS;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= PASS;
      ceil_reg      <= DEFAULT_DUTY;
      duty_reg      <= DEFAULT_DUTY;
      presc_reg     <= '0;
      hold_cnt_reg  <= 8'd0;
      dir_down_reg  <= 1'b0;
      ramp_done_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      ceil_reg      <= ceil_next;
      duty_reg      <= duty_next;
      presc_reg     <= presc_next;
      hold_cnt_reg  <= hold_cnt_next;
      dir_down_reg  <= dir_down_next;
      ramp_done_reg <= ramp_done_next;
    end
  end

  assign phase     = state_reg;
  assign ramp_done = ramp_done_reg;

`ifdef FADE_GAMMA_EN
  logic [15:0] gamma_sq;
  logic [7:0]  gamma_duty;

  // Rounded-up square law keeps 1 -> 1 and 255 -> 255; PASS output stays linear.
  always_comb begin
    gamma_sq   = ({8'd0, duty_reg} * {8'd0, duty_reg}) + 16'd255;
    gamma_duty = gamma_sq[15:8];
    duty_out   = (state_reg == PASS) ? duty_reg : gamma_duty;
  end
`else
  assign duty_out = duty_reg;
`endif

endmodule

// File: tb/tb_pwm_fade_sequencer.sv
// Directed self-checking bench for pwm_fade_sequencer (default parameters).
module tb_pwm_fade_sequencer;

  localparam logic [1:0] P_PASS = 2'b00;
  localparam logic [1:0] P_UP   = 2'b01;
  localparam logic [1:0] P_HOLD = 2'b10;
  localparam logic [1:0] P_DOWN = 2'b11;

  // Expected per-cycle outputs for ceil=0x10, step=4, tick_div=0, hold_ticks=0.
  localparam logic [7:0] BASIC_DUTY  [12] = '{8'd0, 8'd4, 8'd8, 8'd12, 8'd16, 8'd16,
                                              8'd12, 8'd8, 8'd4, 8'd0, 8'd0, 8'd4};
  localparam logic [1:0] BASIC_PHASE [12] = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b11,
                                              2'b11, 2'b11, 2'b11, 2'b10, 2'b01, 2'b01};
  localparam logic       BASIC_RAMP  [12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                              1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fade_en;
  logic [7:0]  spi_duty;
  logic        spi_duty_wr;
  logic [7:0]  step;
  logic [15:0] tick_div;
  logic [7:0]  hold_ticks;
  logic [7:0]  duty_out;
  logic [1:0]  phase;
  logic        ramp_done;

  int errors = 0;
  int checks = 0;

  pwm_fade_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .fade_en    (fade_en),
    .spi_duty   (spi_duty),
    .spi_duty_wr(spi_duty_wr),
    .step       (step),
    .tick_div   (tick_div),
    .hold_ticks (hold_ticks),
    .duty_out   (duty_out),
    .phase      (phase),
    .ramp_done  (ramp_done)
  );

  always #5 clk = ~clk;

  // Advance one clock; outputs are stable 1 time unit after the edge.
  task automatic step_clk();
    @(posedge clk);
    #1;
  endtask

  task automatic write_ceil(input logic [7:0] value);
    spi_duty    = value;
    spi_duty_wr = 1'b1;
    step_clk();
    spi_duty_wr = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; fade_en = 1'b0; spi_duty = 8'h5A; spi_duty_wr = 1'b0;
    step = 8'd1; tick_div = 16'd0; hold_ticks = 8'd0;
    step_clk();
    step_clk();
    checks++;
    if (duty_out !== 8'h00) begin errors++; $display("FAIL reset_duty: got %h want 00", duty_out); end
    checks++;
    if (phase !== P_PASS) begin errors++; $display("FAIL reset_phase: got %b want 00", phase); end
    checks++;
    if (ramp_done !== 1'b0) begin errors++; $display("FAIL reset_ramp: got %b want 0", ramp_done); end
    rst_n = 1'b1;
    step_clk();
    write_ceil(8'h80);
    checks++;
    if (duty_out !== 8'h80) begin errors++; $display("FAIL pass_latency: got %h want 80", duty_out); end
    $display("test_reset done: duty_out=%h phase=%b", duty_out, phase);
  endtask

  task automatic test_fade_basic();
    int ramp_count = 0;
    write_ceil(8'h10);
    step = 8'd4; tick_div = 16'd0; hold_ticks = 8'd0; fade_en = 1'b1;
    for (int k = 0; k < 12; k++) begin
      step_clk();
      if (ramp_done === 1'b1) ramp_count++;
      checks++;
      if (duty_out !== BASIC_DUTY[k] || phase !== BASIC_PHASE[k] || ramp_done !== BASIC_RAMP[k]) begin
        errors++;
        $display("FAIL basic_cycle%0d: got duty=%h phase=%b ramp=%b want duty=%h phase=%b ramp=%b",
                 k, duty_out, phase, ramp_done, BASIC_DUTY[k], BASIC_PHASE[k], BASIC_RAMP[k]);
      end
    end
    checks++;
    if (ramp_count != 1) begin errors++; $display("FAIL basic_ramp_count: got %0d want 1", ramp_count); end
    fade_en = 1'b0;
    step_clk();
    checks++;
    if (phase !== P_PASS || duty_out !== 8'h10) begin
      errors++; $display("FAIL basic_exit: got phase=%b duty=%h want 00/10", phase, duty_out);
    end
    $display("test_fade_basic done: ramp pulses=%0d", ramp_count);
  endtask

  task automatic test_saturate();
    write_ceil(8'hFF);
    step = 8'hF0; tick_div = 16'd3; hold_ticks = 8'd0; fade_en = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      step_clk();
      if (k == 4) begin
        checks++;
        if (duty_out !== 8'h00) begin errors++; $display("FAIL sat_pre_tick: got %h want 00", duty_out); end
      end
      if (k == 5 || k == 8) begin
        checks++;
        if (duty_out !== 8'hF0 || phase !== P_UP) begin
          errors++; $display("FAIL sat_first_step k=%0d: got %h/%b want F0/01", k, duty_out, phase);
        end
      end
      if (k == 9) begin
        checks++;
        if (duty_out !== 8'hFF || phase !== P_HOLD) begin
          errors++; $display("FAIL sat_clamp: got %h/%b want FF/10", duty_out, phase);
        end
      end
    end
    fade_en = 1'b0;
    step_clk();
    step = 8'd0; tick_div = 16'd0; fade_en = 1'b1;
    for (int k = 1; k <= 3; k++) step_clk();
    checks++;
    if (duty_out !== 8'h02 || phase !== P_UP) begin
      errors++; $display("FAIL step_zero: got %h/%b want 02/01", duty_out, phase);
    end
    fade_en = 1'b0;
    step_clk();
    $display("test_saturate done: duty_out=%h", duty_out);
  endtask

  task automatic test_ceil_change();
    write_ceil(8'hFF);
    step = 8'h20; tick_div = 16'd3; hold_ticks = 8'd0; fade_en = 1'b1;
    for (int k = 1; k <= 22; k++) begin
      step_clk();
      if (k == 13) begin
        checks++;
        if (duty_out !== 8'h60 || phase !== P_UP) begin
          errors++; $display("FAIL lower_pre: got %h/%b want 60/01", duty_out, phase);
        end
        spi_duty = 8'h40; spi_duty_wr = 1'b1;
      end
      if (k == 14) spi_duty_wr = 1'b0;
      if (k == 16) begin
        checks++;
        if (duty_out !== 8'h60 || phase !== P_UP) begin
          errors++; $display("FAIL lower_wait: got %h/%b want 60/01", duty_out, phase);
        end
      end
      if (k == 17) begin
        checks++;
        if (duty_out !== 8'h40 || phase !== P_HOLD) begin
          errors++; $display("FAIL lower_clamp: got %h/%b want 40/10", duty_out, phase);
        end
      end
      if (k == 21) begin
        checks++;
        if (duty_out !== 8'h40 || phase !== P_DOWN) begin
          errors++; $display("FAIL lower_down: got %h/%b want 40/11", duty_out, phase);
        end
        fade_en = 1'b0; spi_duty = 8'h22; spi_duty_wr = 1'b1;
      end
      if (k == 22) begin
        checks++;
        if (duty_out !== 8'h22 || phase !== P_PASS || ramp_done !== 1'b0) begin
          errors++; $display("FAIL abort_write: got %h/%b/%b want 22/00/0", duty_out, phase, ramp_done);
        end
        spi_duty_wr = 1'b0;
      end
    end
    $display("test_ceil_change done: duty_out=%h phase=%b", duty_out, phase);
  endtask

  task automatic test_hold_reset();
    int hold_bad = 0;
    write_ceil(8'h10);
    step = 8'd8; tick_div = 16'd1; hold_ticks = 8'd2; fade_en = 1'b1;
    for (int k = 1; k <= 34; k++) begin
      step_clk();
      if ((k >= 5 && k <= 10) || (k >= 15 && k <= 20)) begin
        if (phase !== P_HOLD) hold_bad++;
      end
      if (k == 11) begin
        checks++;
        if (phase !== P_DOWN || duty_out !== 8'h10) begin
          errors++; $display("FAIL peak_hold_exit: got %b/%h want 11/10", phase, duty_out);
        end
      end
      if (k == 15) begin
        checks++;
        if (ramp_done !== 1'b1 || duty_out !== 8'h00) begin
          errors++; $display("FAIL floor_ramp: got ramp=%b duty=%h want 1/00", ramp_done, duty_out);
        end
      end
      if (k == 16) begin
        checks++;
        if (ramp_done !== 1'b0) begin errors++; $display("FAIL ramp_width: got %b want 0", ramp_done); end
      end
      if (k == 21) begin
        checks++;
        if (phase !== P_UP) begin errors++; $display("FAIL floor_hold_exit: got %b want 01", phase); end
      end
      if (k == 33) begin
        checks++;
        if (phase !== P_DOWN || duty_out !== 8'h08) begin
          errors++; $display("FAIL mid_down: got %b/%h want 11/08", phase, duty_out);
        end
        rst_n = 1'b0;
      end
      if (k == 34) begin
        checks++;
        if (phase !== P_PASS || duty_out !== 8'h00 || ramp_done !== 1'b0) begin
          errors++; $display("FAIL mid_reset: got %b/%h/%b want 00/00/0", phase, duty_out, ramp_done);
        end
        rst_n = 1'b1; fade_en = 1'b0;
      end
    end
    checks++;
    if (hold_bad != 0) begin errors++; $display("FAIL hold_length: got %0d non-HOLD cycles want 0", hold_bad); end
    step_clk();
    checks++;
    if (duty_out !== 8'h00 || phase !== P_PASS) begin
      errors++; $display("FAIL ceil_after_reset: got %h/%b want 00/00", duty_out, phase);
    end
    $display("test_hold_reset done: duty_out=%h phase=%b", duty_out, phase);
  endtask

`ifdef FADE_GAMMA_EN
  task automatic test_gamma();
    write_ceil(8'h80);
    checks++;
    if (duty_out !== 8'h80) begin errors++; $display("FAIL gamma_pass: got %h want 80", duty_out); end
    write_ceil(8'hFF);
    step = 8'h80; tick_div = 16'd0; hold_ticks = 8'd0; fade_en = 1'b1;
    step_clk();
    step_clk();
    checks++;
    if (duty_out !== 8'h40) begin errors++; $display("FAIL gamma_80: got %h want 40", duty_out); end
    step_clk();
    checks++;
    if (duty_out !== 8'hFF) begin errors++; $display("FAIL gamma_ff: got %h want FF", duty_out); end
    fade_en = 1'b0;
    step_clk();
    $display("test_gamma done: duty_out=%h", duty_out);
  endtask
`endif

  initial begin
    test_reset();
    test_fade_basic();
    test_saturate();
    test_ceil_change();
    test_hold_reset();
`ifdef FADE_GAMMA_EN
    test_gamma();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pwm_fade_sequencer.md
Name: pwm_fade_sequencer

Overview:
Controller that sequences the duty-cycle setting of the PWM datapath. It sits between the SPI register bank's duty register and the PWM peripheral's duty input. In pass-through mode it forwards the SPI-written duty value. In fade mode it runs an autonomous triangle ramp between 0 and the SPI-written ceiling, with a programmable step, tick rate and dwell time.

Parameters:
PRESCALE_W, 16, width of tick prescaler counter and tick_div input
DEFAULT_DUTY, 8'h00, reset value of ceiling register and duty_out

Ports:
clk  input  1  system clock
rst_n  input  1  reset; synchronous, active-low
fade_en  input  1  1 = autonomous fade, 0 = pass-through
spi_duty  input  8  duty value from SPI register bank
spi_duty_wr  input  1  one-cycle pulse when SPI writes the duty register
step  input  8  duty increment/decrement per tick; 0 is treated as 1
tick_div  input  PRESCALE_W  clk cycles per tick minus 1
hold_ticks  input  8  extra ticks to dwell at peak and floor
duty_out  output  8  duty value to PWM peripheral
phase  output  2  state: 00 PASS, 01 UP, 10 HOLD, 11 DOWN
ramp_done  output  1  one-cycle pulse when a fade cycle returns to floor

Behaviour:
- Reset (rst_n low at posedge clk):
  - state = PASS; ceil = DEFAULT_DUTY; duty = DEFAULT_DUTY.
  - Prescaler, hold counter and dir bit cleared; ramp_done = 0.
- Ceiling register: on spi_duty_wr, ceil <= spi_duty in every state. This takes priority over any other event in the same cycle.
- Prescaler:
  - Counts 0..tick_div. A tick fires in a cycle where count >= tick_div, and the count returns to 0.
  - tick_div = 0 gives a tick every cycle.
  - If tick_div is lowered below the current count, the tick fires immediately.
  - The prescaler is cleared on PASS->UP.
- PASS:
  - duty = ceil. An spi_duty_wr at cycle N is visible on duty_out at N+1.
  - If fade_en = 1: go to UP, duty <= 0, prescaler <= 0.
- Any fade state with fade_en = 0: go to PASS next cycle, duty <= ceil (uses the new value if spi_duty_wr is in the same cycle). ramp_done is not pulsed.
- UP, on tick:
  - duty <= min(duty + step, ceil), with a 9-bit sum (no 8-bit wrap).
  - If the new duty == ceil: go to HOLD, dir = down, hold_cnt <= 0.
  - If ceil is lowered below duty, the next tick clamps duty to ceil and goes to HOLD.
- HOLD, on tick:
  - If hold_cnt == hold_ticks: go to DOWN (dir = down) or UP (dir = up).
  - Otherwise hold_cnt++.
  - hold_ticks = 0 leaves on the first tick. duty is unchanged.
- DOWN, on tick:
  - duty <= (duty <= step) ? 0 : duty - step.
  - If the new duty == 0: go to HOLD, dir = up, hold_cnt <= 0, and ramp_done = 1 for exactly that cycle, coincident with duty_out first becoming 0.
- ceil = 0 while fading: UP reaches ceil on the first tick, DOWN reaches 0 on its first tick. The state still cycles and ramp_done still pulses; duty_out stays 0.
- Outputs:
  - All state, duty and ramp_done are registered.
  - phase reflects the current state.
  - duty_out = duty; the optional gamma mapping below applies only when the feature is compiled in.

Optional Feature:
Macro FADE_GAMMA_EN.
- Defined: in UP, HOLD and DOWN, duty_out = (duty*duty + 255) >> 8, a 16-bit product (square law; 0->0, 1->1, 128->64, 255->255).
  - The mapping is combinational from the duty register, so it adds no latency.
  - PASS output is not mapped.
- Not defined: duty_out = duty in all states, and no multiplier is instantiated.

Test Plan:
- Reset with DEFAULT_DUTY=0 -> duty_out=0, phase=00, ramp_done=0. Then spi_duty=0x80 with spi_duty_wr pulse at cycle N -> duty_out=0x80 at N+1.
- ceil=0x10, step=4, tick_div=0, hold_ticks=0, fade_en=1:
  - duty_out = 0,4,8,12,16, then HOLD 1 tick, then 12,8,4,0.
  - ramp_done high only on the cycle duty_out returns to 0; phase sequence 01,10,11,10,01.
- ceil=0xFF, step=0xF0, tick_div=3 -> duty 0 -> 0xF0 -> 0xFF (saturates, no wrap), steps 4 clk apart. step=0 -> duty increments by 1 per tick.
- In UP at duty=0x60, spi_duty_wr with spi_duty=0x40 -> next tick duty=0x40, phase=10. In DOWN, drop fade_en with simultaneous write of 0x22 -> next cycle phase=00, duty_out=0x22, no ramp_done.
- hold_ticks=2, tick_div=1 -> HOLD lasts 3 ticks = 6 clk at both peak and floor. Assert rst_n low mid-DOWN -> next cycle phase=00, duty_out=DEFAULT_DUTY.
- With FADE_GAMMA_EN: UP values 0x80 and 0xFF -> duty_out 0x40 and 0xFF; PASS with ceil 0x80 -> duty_out 0x80.
